// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel stage of the grayscale-to-Sobel pipeline.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package sobel_pkg;

  localparam int DEFAULT_WIDTH  = 720;
  localparam int DEFAULT_HEIGHT = 720;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ctrl_state_t;

  // Per-pixel token carried alongside the kernel datapath
  typedef struct packed {
    logic valid;
    logic border;
  } token_t;

endpackage

// File: rtl/sobel_token_pipe.sv
// Fixed-depth token delay line that tracks valid/border through a fixed-latency stage.
// Latency: LAT enabled cycles from in_tok to out_tok.
// Backpressure: the whole line freezes while en=0; bubbles enter whenever en=1.
module sobel_token_pipe
  import sobel_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  token_t in_tok,
  output token_t out_tok
);

  token_t stage [LAT];

  // Shift tokens one stage per enabled cycle; reset discards everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) stage[i] <= '0;
    end else if (en) begin
      stage[0] <= in_tok;
      for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign out_tok = stage[LAT-1];

endmodule

// File: rtl/sobel_stream_ctrl.sv
// Sobel stage sequencer: paces window shifts, flushes with zeros, tags border outputs.
// Latency: a write follows its shift by KERNEL_LAT pipe_en cycles; handshake is combinational.
// Backpressure: a valid tail token with out_full freezes shifting and the kernel pipe.
// Optional statistics ports (frame_cnt, stall_cnt) are built when SOBEL_CTRL_STATS_EN is defined.
module sobel_stream_ctrl
  import sobel_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int HEIGHT     = DEFAULT_HEIGHT,
  parameter int KERNEL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_empty,
  output logic        in_rd_en,
  output logic        shift_en,
  output logic        shift_zero,
  output logic        pipe_en,
  input  logic        out_full,
  output logic        out_wr_en,
  output logic        out_sel_zero,
  output logic        frame_done
`ifdef SOBEL_CTRL_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int KW = $clog2(N + WIDTH + 2);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int WC = $clog2(N);

  // Shift-count milestones within one frame
  localparam logic [KW-1:0] K_RUN   = KW'(WIDTH + 1);
  localparam logic [KW-1:0] K_TOK   = KW'(WIDTH + 2);
  localparam logic [KW-1:0] K_DRAIN = KW'(N);
  localparam logic [KW-1:0] K_END   = KW'(N + WIDTH + 1);

  ctrl_state_t   state;
  logic [KW-1:0] k;
  logic [KW-1:0] k_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [WC-1:0] wr_cnt;
  logic          inject;
  token_t        in_tok;
  token_t        tail_tok;

  assign k_nxt = k + 1'b1;

  // The kernel stalls only when a real result is waiting on a full output FIFO
  always_comb pipe_en = !(tail_tok.valid && out_full);

  // Window shift / FIFO pop: real pixels in FILL and RUN, zero flush in DRAIN
  always_comb begin
    shift_en   = 1'b0;
    shift_zero = 1'b0;
    in_rd_en   = 1'b0;
    if (!rst) begin
      if (state == DRAIN) begin
        shift_en   = pipe_en;
        shift_zero = pipe_en;
      end else begin
        shift_en = pipe_en && !in_empty;
        in_rd_en = pipe_en && !in_empty;
      end
    end
  end

  // Once the window holds a full neighbourhood, every shift produces one centre pixel
  always_comb begin
    inject        = shift_en && (k_nxt >= K_TOK);
    in_tok.valid  = inject;
    in_tok.border = inject && ((row == '0) || (row == RW'(HEIGHT - 1)) ||
                               (col == '0) || (col == CW'(WIDTH - 1)));
  end

  sobel_token_pipe #(
    .LAT (KERNEL_LAT)
  ) u_token_pipe (
    .clk     (clk),
    .rst     (rst),
    .en      (pipe_en),
    .in_tok  (in_tok),
    .out_tok (tail_tok)
  );

  // Output side: write each valid tail token, zeroing border centres
  always_comb begin
    out_wr_en    = tail_tok.valid && !out_full;
    out_sel_zero = tail_tok.valid && tail_tok.border;
    frame_done   = out_wr_en && (wr_cnt == WC'(N - 1));
  end

  // Frame sequencer: shift count, phase, and raster position of the next centre
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      k     <= '0;
      row   <= '0;
      col   <= '0;
    end else if (shift_en) begin
      k <= k_nxt;
      if (inject) begin
        if (col == CW'(WIDTH - 1)) begin
          col <= '0;
          row <= (row == RW'(HEIGHT - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      case (state)
        FILL:    if (k_nxt == K_RUN)   state <= RUN;
        RUN:     if (k_nxt == K_DRAIN) state <= DRAIN;
        DRAIN: begin
          if (k_nxt == K_END) begin
            state <= FILL;
            k     <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Output write counter; independent of the shift side so frames may overlap
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= '0;
    end else if (out_wr_en) begin
      wr_cnt <= (wr_cnt == WC'(N - 1)) ? '0 : wr_cnt + 1'b1;
    end
  end

`ifdef SOBEL_CTRL_STATS_EN
  // Frame count wraps; stall count saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (frame_done) frame_cnt <= frame_cnt + 1'b1;
      if (!pipe_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Directed bench for sobel_stream_ctrl at WIDTH=4, HEIGHT=3, KERNEL_LAT=2.
// Models a show-ahead input FIFO with a pixel budget and a switchable full output FIFO.
// Checks reset state, write count/border pattern, zero flush, frame_done, stalls and rst.
module tb_sobel_stream_ctrl;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int LAT = 2;
  localparam int NPX = W * H;

  logic clk = 1'b0;
  logic rst, in_empty, out_full;
  logic in_rd_en, shift_en, shift_zero, pipe_en, out_wr_en, out_sel_zero, frame_done;
`ifdef SOBEL_CTRL_STATS_EN
  logic [15:0] frame_cnt;
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  sobel_stream_ctrl #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .KERNEL_LAT (LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_empty     (in_empty),
    .in_rd_en     (in_rd_en),
    .shift_en     (shift_en),
    .shift_zero   (shift_zero),
    .pipe_en      (pipe_en),
    .out_full     (out_full),
    .out_wr_en    (out_wr_en),
    .out_sel_zero (out_sel_zero),
    .frame_done   (frame_done)
`ifdef SOBEL_CTRL_STATS_EN
    ,
    .frame_cnt    (frame_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  int cyc = 0, pix_left = 0, wr_count = 0, fd_count = 0, zs_count = 0, shift_count = 0;
  int rd_viol = 0, full_left = 0, stall_bad = 0, stall_seen = 0;
  int t_shift6 = -1, t_wr1 = -1;
  bit toggle = 1'b0, stall_arm = 1'b0;
  logic wr_log[$];
  int   fd_pos[$];
  // bit i = expected out_sel_zero of write i in a frame: only centres (1,1),(1,2) are interior
  logic [11:0] exp_border = 12'b1111_1001_1111;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs after the rising edge, sample outputs on the falling edge
  task automatic tick();
    @(posedge clk);
    #1;
    out_full = (full_left > 0);
    if (full_left > 0) full_left--;
    in_empty = (pix_left == 0) || (toggle && cyc[0]);
    @(negedge clk);
    cyc++;
    if (in_rd_en && in_empty) rd_viol++;
    if (shift_en && !shift_zero && in_empty) rd_viol++;
    if (in_rd_en && pix_left > 0) pix_left--;
    if (shift_en) begin
      shift_count++;
      if (shift_count == W + 2 && t_shift6 < 0) t_shift6 = cyc;
    end
    if (shift_en && shift_zero) zs_count++;
    if (out_wr_en) begin
      wr_log.push_back(out_sel_zero);
      wr_count++;
      if (t_wr1 < 0) t_wr1 = cyc;
      if (stall_arm) begin
        full_left = 10;
        stall_arm = 1'b0;
      end
    end
    if (frame_done) begin
      fd_count++;
      fd_pos.push_back(wr_count);
    end
    if (out_full) begin
      if (pipe_en || shift_en || out_wr_en) stall_bad++;
      if (!pipe_en) stall_seen++;
    end
  endtask

  task automatic run_until(input int target, input int budget);
    int n = 0;
    while (wr_count < target && n < budget) begin
      tick();
      n++;
    end
    repeat (10) tick();
  endtask

  task automatic check_frames(input string tag, input int bw, input int bf, input int bz,
                              input int nfr);
    logic obs;
    int   idx, pos;
    check({tag, "_writes"}, wr_count - bw, NPX * nfr);
    check({tag, "_frame_done_cnt"}, fd_count - bf, nfr);
    check({tag, "_zero_shifts"}, zs_count - bz, (W + 1) * nfr);
    for (int f = 0; f < nfr; f++) begin
      pos = (bf + f < fd_pos.size()) ? fd_pos[bf + f] : -1;
      check($sformatf("%s_frame_done_at_f%0d", tag, f), pos, bw + NPX * (f + 1));
      for (int i = 0; i < NPX; i++) begin
        idx = bw + NPX * f + i;
        obs = (idx < wr_log.size()) ? wr_log[idx] : 1'bx;
        check($sformatf("%s_sel_zero_f%0d_w%0d", tag, f, i + 1), obs, exp_border[i]);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_rd_en"}, in_rd_en, 1'b0);
    check({tag, "_shift_en"}, shift_en, 1'b0);
    check({tag, "_shift_zero"}, shift_zero, 1'b0);
    check({tag, "_out_wr_en"}, out_wr_en, 1'b0);
    check({tag, "_out_sel_zero"}, out_sel_zero, 1'b0);
    check({tag, "_frame_done"}, frame_done, 1'b0);
    check({tag, "_pipe_en"}, pipe_en, 1'b1);
  endtask

  initial begin
    int bw, bf, bz, bs;

    // Reset state
    rst = 1'b1;
    in_empty = 1'b1;
    out_full = 1'b0;
    repeat (3) tick();
    check_reset_outputs("por");
    rst = 1'b0;

    // Single frame, FIFO never empty, output never full
    bw = wr_count; bf = fd_count; bz = zs_count;
    pix_left = NPX;
    run_until(bw + NPX, 300);
    check_frames("basic", bw, bf, bz, 1);
    check("basic_shift_to_write_lat", t_wr1 - t_shift6, LAT);
    check("basic_pixels_popped", pix_left, 0);

    // Input FIFO empty every other cycle
    bw = wr_count; bf = fd_count; bz = zs_count;
    toggle = 1'b1;
    pix_left = NPX;
    run_until(bw + NPX, 300);
    toggle = 1'b0;
    check_frames("toggle", bw, bf, bz, 1);
    check("toggle_read_while_empty", rd_viol, 0);

    // Reset after 7 shifts, then a clean frame
    bs = shift_count;
    pix_left = NPX;
    for (int n = 0; n < 100 && shift_count < bs + 7; n++) tick();
    check("midrst_shifts_before_rst", shift_count - bs, 7);
    tick();
    rst = 1'b1;
    pix_left = 0;
    in_empty = 1'b1;
    tick();
    check_reset_outputs("midrst");
`ifdef SOBEL_CTRL_STATS_EN
    check("midrst_frame_cnt", frame_cnt, 0);
    check("midrst_stall_cnt", stall_cnt, 0);
`endif
    rst = 1'b0;
    bw = wr_count; bf = fd_count; bz = zs_count;
    pix_left = NPX;
    run_until(bw + NPX, 300);
    check_frames("postrst", bw, bf, bz, 1);

    // Output full for 10 cycles once the first result is at the tail
    bw = wr_count; bf = fd_count; bz = zs_count;
    stall_arm = 1'b1;
    pix_left = NPX;
    run_until(bw + NPX, 300);
    check_frames("stall", bw, bf, bz, 1);
    check("stall_cycles_seen", stall_seen, 10);
    check("stall_activity_while_full", stall_bad, 0);

    // Two frames back to back; frame 2 starts on a stale window
    bw = wr_count; bf = fd_count; bz = zs_count;
    pix_left = 2 * NPX;
    run_until(bw + 2 * NPX, 600);
    check_frames("b2b", bw, bf, bz, 2);
    check("total_read_while_empty", rd_viol, 0);

`ifdef SOBEL_CTRL_STATS_EN
    // Frames since the mid-frame reset: postrst, stall, and two back-to-back
    check("stats_frame_cnt", frame_cnt, 4);
    check("stats_stall_cnt", stall_cnt, 10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
